scan_ctrl4: RTL and testbench

Four-digit scan sequencer that sits directly upstream of the 2:4 decoder. It drives the decoder select pair (a, b) with a prescaled rotating digit index. It also presents the nibble for the currently selected digit. New 16-bit display words arrive on a load/ready handshake and are applied only at frame boundaries, so a frame never shows a mix of old and new data.

---
 rtl/scan_ctrl4_pkg.sv | 17 +
 rtl/scan_prescaler.sv | 31 +++
 rtl/scan_ctrl4.sv | 120 ++++++++++++
 tb/tb_scan_ctrl4.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl4_pkg.sv
// Shared definitions for the four-digit scan sequencer:
// FSM state encoding, digit geometry and default timing.
package scan_ctrl4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int NDIG         = 4;
    localparam int DIGW         = 2;
    localparam int NIBW         = 4;
    localparam int WORDW        = NDIG * NIBW;
    localparam int PRESCALE_DEF = 4;
    localparam int PW_DEF       = 8;

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 while en, then wraps.
// Ports: clk, rst (async high), clr (sync clear), en; wrap = last count.
module scan_prescaler #(
    parameter int PRESCALE = 4,
    parameter int PW       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    assign wrap = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (wrap) count <= '0;
            else      count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/scan_ctrl4.sv
// Four-digit scan sequencer feeding a 2:4 decoder. Display words are
// taken on load/ready and applied only at frame boundaries.
// Ports: clk, rst (async high), en, load, din[15:0] -> ready, a, b,
//        nib[3:0], tick, frame, blank.
// Optional leading-zero blanking: define SCAN_CTRL4_LZB_EN.
module scan_ctrl4
    import scan_ctrl4_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int PW       = PW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WORDW-1:0] din,
    output logic             ready,
    output logic             a,
    output logic             b,
    output logic [NIBW-1:0]  nib,
    output logic             tick,
    output logic             frame,
    output logic             blank
);

    state_t            state;
    state_t            state_nx;
    logic [DIGW-1:0]   digit;
    logic [WORDW-1:0]  active;
    logic [WORDW-1:0]  pending;
    logic              pend_v;
    logic              wrap;
    logic              in_scan;
    logic              clr;
    logic              take;

    assign in_scan = (state == ST_SCAN);
    // Counters are held at zero in IDLE and cleared on the exit edge.
    assign clr     = ~in_scan | ~en;
    assign take    = load & ~pend_v;

    assign ready = ~pend_v;
    assign tick  = in_scan & wrap;
    assign frame = tick & (digit == DIGW'(NDIG - 1));
    assign a     = digit[1];
    assign b     = digit[0];
    assign nib   = active[NIBW*digit +: NIBW];

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (in_scan),
        .wrap (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (en)  state_nx = ST_SCAN;
            ST_SCAN: if (!en) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (tick) begin
            digit <= digit + DIGW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
        end else if (!in_scan) begin
            if (take) active <= din;
        end else if (!en) begin
            // Leaving SCAN: newest word wins so nothing is stranded
            // in pending while the scan is stopped.
            if (take)        active <= din;
            else if (pend_v) active <= pending;
            pend_v <= 1'b0;
        end else if (frame && pend_v) begin
            active <= pending;
            pend_v <= 1'b0;
        end else if (take) begin
            pending <= din;
            pend_v  <= 1'b1;
        end
    end

`ifdef SCAN_CTRL4_LZB_EN
    always_comb begin
        blank = 1'b0;
        unique case (digit)
            2'd1:    blank = (active[15:4]  == '0);
            2'd2:    blank = (active[15:8]  == '0);
            2'd3:    blank = (active[15:12] == '0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_scan_ctrl4.sv
// Randomised self-checking bench for scan_ctrl4 against a frame-
// position reference model (PRESCALE=4, 16 cycles per frame).
module tb_scan_ctrl4;

    localparam int PS = 4;
    localparam int FRAME_LEN = 4 * PS;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic        ready;
    logic        a;
    logic        b;
    logic [3:0]  nib;
    logic        tick;
    logic        frame;
    logic        blank;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position plus a one-deep word queue.
    bit        m_scan;
    int        m_pos;
    int        m_act;
    int        m_pend[$];

    always #5 clk = ~clk;

    scan_ctrl4 #(
        .PRESCALE (PS),
        .PW       (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .din   (din),
        .ready (ready),
        .a     (a),
        .b     (b),
        .nib   (nib),
        .tick  (tick),
        .frame (frame),
        .blank (blank)
    );

    task automatic chk(input string tag,
                       input int got,
                       input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_scan = 0;
        m_pos  = 0;
        m_act  = 0;
        m_pend.delete();
    endfunction

    function automatic void model_edge(bit e, bit l, int d);
        bit acc;
        acc = l && (m_pend.size() == 0);
        if (!m_scan) begin
            if (acc) m_act = d;
            if (e) begin
                m_scan = 1;
                m_pos  = 0;
            end
        end else if (!e) begin
            if (acc)                    m_act = d;
            else if (m_pend.size() > 0) m_act = m_pend.pop_front();
            m_pend.delete();
            m_scan = 0;
            m_pos  = 0;
        end else begin
            if (m_pos == FRAME_LEN - 1 && m_pend.size() > 0)
                m_act = m_pend.pop_front();
            else if (acc)
                m_pend.push_back(d);
            m_pos = (m_pos + 1) % FRAME_LEN;
        end
    endfunction

    function automatic int m_dig();
        return m_scan ? (m_pos / PS) : 0;
    endfunction

    task automatic check_all();
        int dg;
        int ex_blank;
        dg = m_dig();
        ex_blank = 0;
`ifdef SCAN_CTRL4_LZB_EN
        if (dg > 0 && ((m_act >> (4 * dg)) == 0)) ex_blank = 1;
`endif
        chk("a", int'(a), dg / 2);
        chk("b", int'(b), dg % 2);
        chk("nib", int'(nib), (m_act >> (4 * dg)) & 15);
        chk("tick", int'(tick),
            int'(m_scan && (m_pos % PS == PS - 1)));
        chk("frame", int'(frame),
            int'(m_scan && (m_pos == FRAME_LEN - 1)));
        chk("ready", int'(ready), int'(m_pend.size() == 0));
        chk("blank", int'(blank), ex_blank);
    endtask

    // Inputs change at negedge; outputs checked at the next negedge.
    task automatic step(input bit e, input bit l, input int d);
        en   = e;
        load = l;
        din  = d[15:0];
        @(posedge clk);
        model_edge(e, l, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to_digit(input int dg);
        for (int i = 0; i < FRAME_LEN + 1; i++) begin
            if (m_scan && m_dig() == dg) break;
            step(1, 0, 0);
        end
        chk("reach_digit", m_dig(), dg);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        din  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // 4321 loaded in IDLE then scanned for two frames.
        step(0, 1, 16'h4321);
        for (int i = 0; i < 2 * FRAME_LEN; i++) step(1, 0, 0);

        // New word queued mid-frame, extra load while busy ignored.
        run_to_digit(1);
        step(1, 1, 16'hABCD);
        step(1, 1, 16'h1111);
        for (int i = 0; i < 2 * FRAME_LEN; i++) step(1, 0, 0);

        // Stop at digit 2, restart.
        run_to_digit(2);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        model_edge(1, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        step(0, 0, 0);

        // Leading-zero pattern 0050 over a full frame.
        step(0, 1, 16'h0050);
        for (int i = 0; i < FRAME_LEN + 2; i++) step(1, 0, 0);
        step(0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit l;
            int d;
            e = ($urandom_range(0, 49) != 0);
            l = ($urandom_range(0, 5) == 0);
            d = $urandom_range(0, 65535);
            if ($urandom_range(0, 3) == 0)
                d = d & 16'h00F0;
            step(e, l, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
